// File: rtl/leb128_reader_pkg.sv
// rtl/leb128_reader_pkg.sv - shared loader constants: LEB128 length limit and reader state encodings
package leb128_reader_pkg;

    localparam int LEB_MAX_BYTES = 5;

    typedef enum logic [1:0] {
        LEB_IDLE   = 2'd0,
        LEB_FETCH  = 2'd1,
        LEB_FINISH = 2'd2,
        LEB_ERR    = 2'd3
    } leb_state_t;

    // Bit position of the payload of byte n (7 payload bits per byte)
    function automatic logic [5:0] leb_shift(input logic [2:0] n);
        return 6'(n) * 6'd7;
    endfunction

endpackage

// File: rtl/leb128_reader.sv
// rtl/leb128_reader.sv - fetches and decodes one u32/i32 LEB128 value from ROM (optional LEB_TIMEOUT_EN)
module leb128_reader
    import leb128_reader_pkg::*;
#(
    parameter int MAX_BYTES      = LEB_MAX_BYTES,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] start_addr,
    input  logic        is_signed,
    output logic [31:0] rom_addr,
    output logic        rom_read_en,
    input  logic [7:0]  rom_data,
    input  logic        rom_ready,
    output logic [31:0] value,
    output logic [31:0] next_addr,
    output logic [2:0]  byte_count,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] MAX_N = 3'(MAX_BYTES);

    if (MAX_BYTES < 1 || MAX_BYTES > 6 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("leb128_reader: MAX_BYTES or TIMEOUT_CYCLES out of range");
    end

    leb_state_t  state, state_d;
    logic [31:0] cur_addr;
    logic        signed_q;
    logic [31:0] acc;
    logic [2:0]  n;
    logic [31:0] value_q;
    logic [31:0] next_addr_q;
    logic [2:0]  byte_count_q;

    logic [2:0]  n_inc;
    logic [5:0]  fill_sh;
    logic [31:0] acc_new;
    logic [31:0] final_val;
    logic        range_ok;
    logic        timed_out;

`ifdef LEB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt;

    // Per-byte wait counter; cleared outside FETCH and on every ROM response
    always_ff @(posedge clk) begin
        if (rst || state != LEB_FETCH || rom_ready) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    assign timed_out = (state == LEB_FETCH) && !rom_ready && (tmo_cnt == TMO_LAST);
`else
    assign timed_out = 1'b0;
`endif

    // Datapath for the byte currently on rom_data: accumulate, sign-fill, length check
    always_comb begin
        n_inc     = n + 3'd1;
        fill_sh   = leb_shift(n_inc);
        acc_new   = acc | ({25'd0, rom_data[6:0]} << leb_shift(n));
        final_val = acc_new;
        if (signed_q && rom_data[6] && fill_sh < 6'd32) begin
            final_val = acc_new | ~((32'd1 << fill_sh) - 32'd1);
        end
        range_ok = 1'b1;
        if (n_inc == MAX_N) begin
            if (signed_q) begin
                range_ok = (rom_data[6:4] == {3{rom_data[3]}});
            end else begin
                range_ok = (rom_data[6:4] == 3'b000);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LEB_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and per-state outputs
    always_comb begin
        state_d     = state;
        busy        = 1'b0;
        rom_read_en = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        case (state)
            LEB_IDLE: begin
                if (start) begin
                    state_d = LEB_FETCH;
                end
            end
            LEB_FETCH: begin
                busy        = 1'b1;
                rom_read_en = 1'b1;
                if (rom_ready) begin
                    if (!rom_data[7]) begin
                        state_d = range_ok ? LEB_FINISH : LEB_ERR;
                    end else if (n_inc == MAX_N) begin
                        state_d = LEB_ERR;
                    end
                end else if (timed_out) begin
                    state_d = LEB_ERR;
                end
            end
            LEB_FINISH: begin
                done    = 1'b1;
                state_d = LEB_IDLE;
            end
            LEB_ERR: begin
                error   = 1'b1;
                state_d = LEB_IDLE;
            end
            default: state_d = LEB_IDLE;
        endcase
    end

    // Request latching, byte accumulation and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr     <= '0;
            signed_q     <= 1'b0;
            acc          <= '0;
            n            <= '0;
            value_q      <= '0;
            next_addr_q  <= '0;
            byte_count_q <= '0;
        end else if (state == LEB_IDLE && start) begin
            cur_addr <= start_addr;
            signed_q <= is_signed;
            acc      <= '0;
            n        <= '0;
        end else if (state == LEB_FETCH && rom_ready) begin
            acc      <= acc_new;
            n        <= n_inc;
            cur_addr <= cur_addr + 32'd1;
            // Results are captured with the final byte so they are valid while done is high
            if (!rom_data[7] && range_ok) begin
                value_q      <= final_val;
                byte_count_q <= n_inc;
                next_addr_q  <= cur_addr + 32'd1;
            end
        end
    end

    assign rom_addr   = cur_addr;
    assign value      = value_q;
    assign next_addr  = next_addr_q;
    assign byte_count = byte_count_q;

endmodule

// File: doc/leb128_reader.md
Name: leb128_reader

Overview:
- Byte-stream decoder between the bytecode ROM port and the wasm loader/decoder.
- Given a start address, fetches bytes over the ROM handshake and decodes one LEB128 value.
  - Unsigned u32 or signed i32.
  - Returns the value, its byte length and the address of the following byte.
- The loader uses it for section sizes, function counts, locals and immediates, so it never handles continuation bits itself.

Parameters:
- MAX_BYTES, 5, maximum encoded length for a 32-bit value; longer encodings are errors.
- TIMEOUT_CYCLES, 16, cycles to wait for rom_ready per byte (used only with LEB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  32  address of first encoded byte.
- is_signed  in  1  1 = sLEB128 (i32), 0 = uLEB128 (u32); latched with start.
- rom_addr  out  32  byte address to ROM.
- rom_read_en  out  1  ROM read enable.
- rom_data  in  8  ROM read data, valid when rom_ready=1.
- rom_ready  in  1  one-cycle ROM data-valid pulse.
- value  out  32  decoded value, held until next start.
- next_addr  out  32  start_addr + byte_count, held.
- byte_count  out  3  encoded length 1..5, held.
- busy  out  1  high from accepted start until done/error.
- done  out  1  one-cycle pulse, result valid.
- error  out  1  one-cycle pulse instead of done on a malformed encoding or timeout.

Behaviour:
- Reset values: value=0, next_addr=0, byte_count=0, busy=0, done=0, error=0, rom_read_en=0, rom_addr=0; state=IDLE.
  - rst mid-decode aborts immediately; no done/error is emitted.
- States:
  - IDLE: on start, latch start_addr into cur_addr, latch is_signed, clear acc/shift/n. Go to FETCH; busy=1 next cycle.
  - FETCH: rom_read_en=1, rom_addr=cur_addr. Wait for rom_ready; start is ignored. On rom_ready:
    - acc |= (rom_data[6:0] << 7*n); n <= n+1; cur_addr <= cur_addr+1.
    - rom_data[7]=0 -> FINISH.
    - rom_data[7]=1 and n+1<MAX_BYTES -> stay in FETCH. The new address is presented the next cycle; the ROM responds only to a changed address.
    - rom_data[7]=1 and n+1==MAX_BYTES -> ERR.
  - FINISH: compute the final value and apply the range check. Registered outputs update, done=1 for one cycle, then IDLE.
  - ERR: error=1 for one cycle, then IDLE. value/byte_count/next_addr are undefined-but-stable and must not be relied on.
- rom_read_en drops to 0 in FINISH/ERR/IDLE.
- Timing with the project ROM model: 2 cycles per byte. done is asserted 1 cycle after the final byte's rom_ready.
- Sign extension: if is_signed and the last byte's bit6=1 and 7*n<32, fill bits [31:7*n] with 1s.
- 5th-byte range check:
  - Unsigned: bits 6:4 must be 0, else ERR.
  - Signed: bits 6:4 must all equal bit 3, else ERR.
- Non-minimal encodings (e.g. 0x80 0x00) are legal and decode normally; byte_count reflects the actual length.
- Boundaries:
  - A start whose first address equals the previous ROM access address receives no rom_ready (ROM quirk). Without the timeout the block stalls in FETCH until rst.
  - cur_addr wraps at 2^32 with no error.
  - start asserted in the same cycle as done is ignored. A new start is accepted only in IDLE, earliest the cycle after done.

Optional Feature:
- LEB_TIMEOUT_EN defined: a per-byte counter resets on entering FETCH and on each rom_ready. Reaching TIMEOUT_CYCLES without rom_ready -> ERR (error pulse, rom_read_en drops).
- Not defined: no counter; FETCH waits indefinitely.

Decomposition:
- Shared platform constants file (alongside OP_STACK_TOP): LEB_MAX_BYTES=5 and state encodings LEB_IDLE/LEB_FETCH/LEB_FINISH/LEB_ERR.
- No sub-module: the accumulate/shift datapath is small and stays inline.

Test Plan:
- Unsigned E5 8E 26 at 0x10 -> value=0x00098765 (624485), byte_count=3, next_addr=0x13, done pulse 1 cycle, error=0.
- Signed C0 BB 78 -> value=0xFFFE1DC0 (-123456), byte_count=3. The same bytes unsigned -> 0x001E1DC0.
- Single byte 7F: signed -> 0xFFFFFFFF; unsigned -> 0x0000007F; byte_count=1, done 3 cycles after start.
- FF FF FF FF 0F unsigned -> 0xFFFFFFFF, byte_count=5. FF FF FF FF 1F unsigned -> error pulse, no done.
- 80 80 80 80 80 01 -> error after 5th byte; ROM never sees address start+5.
- rst asserted mid-FETCH -> next cycle busy=0, rom_read_en=0, no done/error. With LEB_TIMEOUT_EN, a ROM that never returns ready -> error exactly TIMEOUT_CYCLES cycles into FETCH.
